// File: rtl/i2c_codec_pkg.sv
// Shared definitions for the codec control-port I2C target: FSM states,
// special register addresses and the codec register map.
package i2c_codec_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        B1,
        ACK1,
        B2,
        ACK2,
        WAIT_STOP,
        NACK_WAIT
    } state_t;

    localparam logic [6:0] REG_RESET_ADDR = 7'h0F;
    localparam logic [7:0] CODEC_WR_BYTE  = 8'h34;

    localparam logic [6:0] R0 = 7'd0;
    localparam logic [6:0] R1 = 7'd1;
    localparam logic [6:0] R2 = 7'd2;
    localparam logic [6:0] R3 = 7'd3;
    localparam logic [6:0] R4 = 7'd4;
    localparam logic [6:0] R5 = 7'd5;
    localparam logic [6:0] R6 = 7'd6;
    localparam logic [6:0] R7 = 7'd7;
    localparam logic [6:0] R8 = 7'd8;
    localparam logic [6:0] R9 = 7'd9;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda and detects START, STOP and scl edges as 1-cycle pulses.
// Latency: SYNC_STAGES+1 clk from pin to pulse.
// No backpressure: pulses are emitted unconditionally.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_in,
    output logic sda_s,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Reset to the idle bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_in};
            scl_d  <= scl_ff[SYNC_STAGES-1];
            sda_d  <= sda_ff[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_ff[SYNC_STAGES-1];
    assign sda_s    = sda_ff[SYNC_STAGES-1];
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

endmodule

// File: rtl/i2c_codec_target.sv
// Write-only I2C target holding the 9-bit codec registers R0..R9.
// Latency: write commits on the scl fall ending the third ACK (+sync delay).
// No backpressure: every ACKed three-byte write commits; others are NACKed or dropped.
module i2c_codec_target
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2,
    parameter int         NUM_REGS    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy,
    output logic [7:0] nack_cnt
);

    logic       sda_s, start, stop, scl_rise, scl_fall;
    state_t     state, state_d;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [6:0] addr_q;
    logic       d8_q;
    logic       oe_d, commit, shift_en, nack_inc, byte_end;
    logic [8:0] regs [NUM_REGS];

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_s    (sda_s),
        .start    (start),
        .stop     (stop),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    assign byte_end = scl_rise && (bit_cnt == 3'd7);

    always_comb begin
        state_d  = state;
        oe_d     = sda_oe;
        commit   = 1'b0;
        shift_en = 1'b0;
        nack_inc = 1'b0;
        if (start) begin
            state_d = DEV;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state)
                DEV: begin
                    shift_en = scl_rise;
                    if (byte_end) begin
                        if ({shreg[6:0], sda_s} == {DEV_ADDR, 1'b0}) begin
                            state_d = DEV_ACK;
                        end else begin
                            state_d  = NACK_WAIT;
                            nack_inc = 1'b1;
                        end
                    end
                end
                B1: begin
                    shift_en = scl_rise;
                    if (byte_end) state_d = ACK1;
                end
                B2: begin
                    shift_en = scl_rise;
                    if (byte_end) state_d = ACK2;
                end
                // First fall after the byte pulls sda, the next fall releases it.
                DEV_ACK, ACK1, ACK2: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d = 1'b0;
                            case (state)
                                DEV_ACK: state_d = B1;
                                ACK1:    state_d = B2;
                                default: begin
                                    state_d = WAIT_STOP;
                                    commit  = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sda_oe   <= 1'b0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            addr_q   <= 7'h00;
            d8_q     <= 1'b0;
            busy     <= 1'b0;
            nack_cnt <= 8'h00;
            wr_valid <= 1'b0;
            wr_addr  <= 7'h00;
            wr_data  <= 9'h000;
        end else begin
            state    <= state_d;
            sda_oe   <= oe_d;
            wr_valid <= commit;
            if (start) busy <= 1'b1;
            else if (stop) busy <= 1'b0;
            if (start || stop) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[6:0], sda_s};
            end
            if (state == B1 && byte_end && !start && !stop) begin
                addr_q <= shreg[6:0];
                d8_q   <= sda_s;
            end
            if (nack_inc && nack_cnt != 8'hFF) nack_cnt <= nack_cnt + 8'd1;
            if (commit) begin
                wr_addr <= addr_q;
                wr_data <= {d8_q, shreg};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'h000;
        end else if (commit) begin
            if (addr_q == REG_RESET_ADDR) begin
                for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'h000;
            end else if (int'(addr_q) < NUM_REGS) begin
                regs[addr_q[3:0]] <= {d8_q, shreg};
            end
        end
    end

    assign rd_data = (int'(rd_addr) < NUM_REGS) ? regs[rd_addr] : 9'h000;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench: bit-banged I2C master with open-drain sda, write scoreboard and monitor.
// Latency/backpressure: n/a (bench).
module tb_i2c_codec_target;
    import i2c_codec_pkg::*;

    localparam int Q = 8;

    typedef struct packed {
        logic [6:0] a;
        logic [8:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_valid, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] nack_cnt;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_codec_target dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .nack_cnt (nack_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_c();
        sda_m = 1'b1; wait_clks(Q);
        scl = 1'b1;   wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl = 1'b0;   wait_clks(Q);
    endtask

    task automatic stop_c();
        scl = 1'b0;   wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl = 1'b1;   wait_clks(Q);
        sda_m = 1'b1; wait_clks(2*Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_clks(Q);
            scl = 1'b1;   wait_clks(2*Q);
            scl = 1'b0;   wait_clks(Q);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input string name, input logic exp_ack);
        logic ack;
        send_bits(b);
        sda_m = 1'b1; wait_clks(Q);
        scl = 1'b1;   wait_clks(Q);
        ack = sda_oe;
        check(name, int'(ack), int'(exp_ack));
        wait_clks(Q);
        scl = 1'b0;   wait_clks(Q);
        check({name, "_release"}, int'(sda_oe), 0);
    endtask

    task automatic wr3(input logic [7:0] b1, input logic [7:0] b2,
                       input logic [6:0] ea, input logic [8:0] ed);
        start_c();
        check("busy_after_start", int'(busy), 1);
        send_byte(CODEC_WR_BYTE, "dev_ack", 1'b1);
        send_byte(b1, "b1_ack", 1'b1);
        exp_q.push_back('{a: ea, d: ed});
        send_byte(b2, "b2_ack", 1'b1);
        stop_c();
        check("busy_after_stop", int'(busy), 0);
    endtask

    task automatic rd_check(input logic [3:0] a, input logic [8:0] exp, input string name);
        rd_addr = a;
        #1;
        check(name, int'(rd_data), int'(exp));
    endtask

    // Scoreboard monitor: every committed write must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && wr_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected actual addr=0x%0h data=0x%0h expected none",
                             wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(wr_addr), int'(e.a));
                    check("wr_data", int'(wr_data), int'(e.d));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    logic [7:0] tbl_b1 [10] = '{8'h00, 8'h02, 8'h05, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h12};
    logic [7:0] tbl_b2 [10] = '{8'h17, 8'h17, 8'h79, 8'h79, 8'h12, 8'h00, 8'h00, 8'h53, 8'h02, 8'h01};
    logic [6:0] tbl_a  [10] = '{R0, R1, R2, R3, R4, R5, R6, R7, R8, R9};
    logic [8:0] tbl_d  [10] = '{9'h017, 9'h017, 9'h179, 9'h079, 9'h012, 9'h000, 9'h000, 9'h053, 9'h002, 9'h001};

    initial begin
        wait_clks(4);
        reset = 1'b0;
        wait_clks(4);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_wr_valid", int'(wr_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_nack_cnt", int'(nack_cnt), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        rd_check(4'd0, 9'h000, "rst_rd0");

        // Basic write: addr 6, data 0x017
        wr3(8'h0C, 8'h17, 7'h06, 9'h017);
        rd_check(4'd6, 9'h017, "rd6_after_write");

        // Addr 0 with data bit 8 set, then codec reset register
        wr3(8'h01, 8'hFF, 7'h00, 9'h1FF);
        rd_check(4'd0, 9'h1FF, "rd0_1ff");
        wr3(8'h1E, 8'h00, 7'h0F, 9'h000);
        for (int i = 0; i < 16; i++) rd_check(4'(i), 9'h000, "rd_after_reg_reset");

        // Wrong address and read bit are NACKed
        start_c();
        send_byte(8'h36, "nack_addr", 1'b0);
        stop_c();
        check("busy_after_nack1", int'(busy), 0);
        check("nack_cnt1", int'(nack_cnt), 1);
        start_c();
        send_byte(8'h35, "nack_read", 1'b0);
        stop_c();
        check("busy_after_nack2", int'(busy), 0);
        check("nack_cnt2", int'(nack_cnt), 2);

        // STOP after first data byte aborts, next write commits
        wr3(8'h04, 8'hAA, 7'h02, 9'h0AA);
        start_c();
        send_byte(CODEC_WR_BYTE, "abort_dev_ack", 1'b1);
        send_byte(8'h06, "abort_b1_ack", 1'b1);
        stop_c();
        check("busy_after_abort", int'(busy), 0);
        rd_check(4'd3, 9'h000, "rd3_after_abort");
        rd_check(4'd2, 9'h0AA, "rd2_after_abort");
        wr3(8'h06, 8'h55, 7'h03, 9'h055);
        rd_check(4'd3, 9'h055, "rd3_after_write");

        // Repeated START mid-transaction restarts decoding, busy held
        start_c();
        send_byte(CODEC_WR_BYTE, "rs_dev_ack", 1'b1);
        send_byte(8'h08, "rs_b1_ack", 1'b1);
        start_c();
        check("busy_after_rstart", int'(busy), 1);
        send_byte(CODEC_WR_BYTE, "rs2_dev_ack", 1'b1);
        send_byte(8'h08, "rs2_b1_ack", 1'b1);
        exp_q.push_back('{a: 7'h04, d: 9'h033});
        send_byte(8'h33, "rs2_b2_ack", 1'b1);
        stop_c();
        rd_check(4'd4, 9'h033, "rd4_after_rstart");

        // Unimplemented address: strobe only
        wr3(8'h14, 8'h01, 7'h0A, 9'h001);
        rd_check(4'd10, 9'h000, "rd10_unimpl");
        rd_check(4'd3, 9'h055, "rd3_unchanged");

        // Codec configuration table, committed in order
        for (int i = 0; i < 10; i++) wr3(tbl_b1[i], tbl_b2[i], tbl_a[i], tbl_d[i]);
        for (int i = 0; i < 10; i++) rd_check(4'(i), tbl_d[i], "table_readback");
        wait_clks(4);
        check("table_done_queue_empty", exp_q.size(), 0);

        // Reset during ACK releases sda without a clock edge
        start_c();
        send_bits(CODEC_WR_BYTE);
        sda_m = 1'b1; wait_clks(Q);
        scl = 1'b1;   wait_clks(Q);
        check("ack_before_reset", int'(sda_oe), 1);
        reset = 1'b1;
        #2;
        check("reset_async_oe", int'(sda_oe), 0);
        wait_clks(2);
        check("mid_rst_wr_addr", int'(wr_addr), 0);
        check("mid_rst_wr_data", int'(wr_data), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_nack", int'(nack_cnt), 0);
        rd_check(4'd2, 9'h000, "mid_rst_rd2");
        reset = 1'b0;
        wait_clks(4);
        stop_c();
        check("busy_end", int'(busy), 0);

        wait_clks(8);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
